liteic_slave_node_read: RTL and testbench

Slave-side read node of the AXI-Lite interconnect: one instance per slave slot, at the crossbar end opposite the master read nodes. It arbitrates among AR requests arriving from all master slots (ARQOS priority, round-robin tie-break), issues one outstanding read at a time on the slave's AXI-Lite port, and returns R data to the granted master through the crossbar response lanes.

---
 rtl/liteic_pkg.sv | 15 +
 rtl/axi_lite_if.sv | 28 ++
 rtl/liteic_qos_rr_arbiter.sv | 42 ++++
 rtl/liteic_slave_node_read.sv | 97 +++++++++
 tb/tb_liteic_slave_node_read.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/liteic_pkg.sv
// liteic_pkg: shared sizing parameters and types for the AXI-Lite interconnect
//   IC_NUM_MASTER_SLOTS - crossbar master lanes
//   IC_ARADDR_WIDTH     - AR address width
//   IC_RDATA_WIDTH      - R payload width, {r_data, r_resp}
package liteic_pkg;

    localparam int IC_NUM_MASTER_SLOTS = 4;
    localparam int IC_ARADDR_WIDTH     = 32;
    localparam int IC_RDATA_WIDTH      = 34;

    typedef logic [3:0] qos_t;

    typedef enum logic [1:0] {IDLE, AR, R} rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI-Lite read channels (AR and R) between an interconnect node and a slave
//   master modport - drives ar_valid/ar_addr/ar_qos/r_ready
//   slave modport  - drives ar_ready/r_valid/r_data/r_resp
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [3:0]            ar_qos;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport master (
        output ar_valid, ar_addr, ar_qos, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, ar_qos, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );

endinterface

// File: rtl/liteic_qos_rr_arbiter.sv
// liteic_qos_rr_arbiter: combinational QoS-priority arbiter with round-robin tie-break
//   req - per-lane request        qos - per-lane priority      ptr - round-robin start lane
//   gnt - one-hot winner          idx - binary winner          any - at least one request
module liteic_qos_rr_arbiter
    import liteic_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  qos_t          qos [N],
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    qos_t        top_q;
    logic [IW:0] lane;
    logic        found;

    always_comb begin
        top_q = '0;
        for (int i = 0; i < N; i++)
            if (req[i] && qos[i] > top_q) top_q = qos[i];
        // Walk the lanes starting at ptr (wrapping); first lane at the top QoS wins
        idx   = '0;
        found = 1'b0;
        lane  = '0;
        for (int k = 0; k < N; k++) begin
            lane = {1'b0, ptr} + (IW+1)'(k);
            if (lane >= (IW+1)'(N)) lane = lane - (IW+1)'(N);
            if (!found && req[lane[IW-1:0]] && qos[lane[IW-1:0]] == top_q) begin
                found = 1'b1;
                idx   = lane[IW-1:0];
            end
        end
        gnt = found ? (N)'(1) << idx : '0;
        any = |req;
    end

endmodule

// File: rtl/liteic_slave_node_read.sv
// liteic_slave_node_read: slave-side read node; arbitrates master AR lanes, runs one read at a time
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   cbar_reqst_*          - per-master AR lanes (valid/ready/address/qos)
//   cbar_resp_*           - per-master R lanes (valid/ready) and shared payload {r_data, r_resp}
//   slv_axil              - AXI-Lite read port toward the slave
module liteic_slave_node_read
    import liteic_pkg::*;
#(
    parameter  int NUM_MASTERS = IC_NUM_MASTER_SLOTS,
    parameter  int ADDR_WIDTH  = IC_ARADDR_WIDTH,
    parameter  int RDATA_WIDTH = IC_RDATA_WIDTH,
    localparam int IW          = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] cbar_reqst_val_i,
    output logic [NUM_MASTERS-1:0] cbar_reqst_rdy_o,
    input  logic [ADDR_WIDTH-1:0]  cbar_reqst_data_i [NUM_MASTERS],
    input  qos_t                   cbar_reqst_arqos_i [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] cbar_resp_val_o,
    input  logic [NUM_MASTERS-1:0] cbar_resp_rdy_i,
    output logic [RDATA_WIDTH-1:0] cbar_resp_data_o,
    axi_lite_if.master             slv_axil
);

    rd_state_t             state_r, state_d;
    logic [IW-1:0]         grant_r, rr_ptr_r, arb_idx;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic                  arb_any;
    logic [ADDR_WIDTH-1:0] addr_r, win_addr;
    qos_t                  qos_r, win_qos;

    liteic_qos_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req (cbar_reqst_val_i),
        .qos (cbar_reqst_arqos_i),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // AND-OR mux of the winning lane's address and QoS, driven by the one-hot grant
    always_comb begin
        win_addr = '0;
        win_qos  = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (arb_gnt[i]) begin
                win_addr = cbar_reqst_data_i[i];
                win_qos  = cbar_reqst_arqos_i[i];
            end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            addr_r   <= '0;
            qos_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_d;
            if (state_r == IDLE && arb_any) begin
                grant_r <= arb_idx;
                addr_r  <= win_addr;
                qos_r   <= win_qos;
            end
            if (state_r == AR && slv_axil.ar_ready)
                rr_ptr_r <= grant_r == IW'(NUM_MASTERS-1) ? '0 : grant_r + 1'b1;
        end
    end

    always_comb begin
        state_d           = state_r;
        cbar_reqst_rdy_o  = '0;
        cbar_resp_val_o   = '0;
        slv_axil.ar_valid = 1'b0;
        slv_axil.r_ready  = 1'b0;
        slv_axil.ar_addr  = addr_r;
        slv_axil.ar_qos   = qos_r;
        cbar_resp_data_o  = RDATA_WIDTH'({slv_axil.r_data, slv_axil.r_resp});
        case (state_r)
            IDLE: state_d = arb_any ? AR : IDLE;
            AR: begin
                slv_axil.ar_valid         = 1'b1;
                cbar_reqst_rdy_o[grant_r] = slv_axil.ar_ready;
                state_d                   = slv_axil.ar_ready ? R : AR;
            end
            R: begin
                cbar_resp_val_o[grant_r] = slv_axil.r_valid;
                slv_axil.r_ready         = cbar_resp_rdy_i[grant_r];
                state_d                  = slv_axil.r_valid && cbar_resp_rdy_i[grant_r] ? IDLE : R;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_liteic_slave_node_read.sv
// tb_liteic_slave_node_read: table-driven self-checking bench for the slave read node
module tb_liteic_slave_node_read;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  val = '0;
    logic [3:0]  rdy;
    logic [31:0] data [4];
    logic [3:0]  qos [4];
    logic [3:0]  resp_val;
    logic [3:0]  resp_rdy = '0;
    logic [33:0] resp_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  val;
        logic [15:0] qos;
        int          idx;
        int          aw;
        int          rw;
        logic [31:0] d;
        logic [1:0]  rs;
        logic        drop;
    } vec_t;

    vec_t vecs [11];

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) slv ();

    liteic_slave_node_read #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .RDATA_WIDTH(34)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cbar_reqst_val_i   (val),
        .cbar_reqst_rdy_o   (rdy),
        .cbar_reqst_data_i  (data),
        .cbar_reqst_arqos_i (qos),
        .cbar_resp_val_o    (resp_val),
        .cbar_resp_rdy_i    (resp_rdy),
        .cbar_resp_data_o   (resp_data),
        .slv_axil           (slv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000 + 32'(i) * 32'h20;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input int aw, input int rw, input logic [31:0] d,
                           input logic [1:0] rs, input logic drop);
        logic [3:0] oh;
        oh = 4'b1 << idx;
        #1;
        chk("idle_ar_valid", 64'(slv.ar_valid), 0);
        chk("idle_reqst_rdy", 64'(rdy), 0);
        @(posedge clk); #1;
        chk("ar_valid", 64'(slv.ar_valid), 1);
        chk("ar_addr", 64'(slv.ar_addr), 64'(addr_of(idx)));
        chk("ar_qos", 64'(slv.ar_qos), 64'(qos[idx]));
        for (int c = 0; c < aw; c++) begin
            chk("ar_wait_rdy", 64'(rdy), 0);
            chk("ar_wait_valid", 64'(slv.ar_valid), 1);
            chk("ar_wait_addr", 64'(slv.ar_addr), 64'(addr_of(idx)));
            @(posedge clk); #1;
        end
        slv.ar_ready = 1'b1;
        #1;
        chk("reqst_rdy", 64'(rdy), 64'(oh));
        @(posedge clk); #1;
        slv.ar_ready = 1'b0;
        if (drop) val[idx] = 1'b0;
        chk("rr_ptr", 64'(dut.rr_ptr_r), 64'((idx + 1) % 4));
        chk("r_state_ar_valid", 64'(slv.ar_valid), 0);
        chk("r_state_reqst_rdy", 64'(rdy), 0);
        chk("r_state_no_rvalid", 64'(resp_val), 0);
        slv.r_valid = 1'b1;
        slv.r_data  = d;
        slv.r_resp  = rs;
        resp_rdy    = ~oh;
        for (int c = 0; c < rw; c++) begin
            #1;
            chk("r_wait_val", 64'(resp_val), 64'(oh));
            chk("r_wait_ready", 64'(slv.r_ready), 0);
            @(posedge clk); #1;
        end
        resp_rdy = 4'hF;
        #1;
        chk("resp_val", 64'(resp_val), 64'(oh));
        chk("resp_data", 64'(resp_data), 64'({d, rs}));
        chk("r_ready", 64'(slv.r_ready), 1);
        @(posedge clk); #1;
        slv.r_valid = 1'b0;
        resp_rdy    = '0;
        chk("post_r_resp_val", 64'(resp_val), 0);
    endtask

    task automatic apply(input int i);
        val = val | vecs[i].val;
        for (int l = 0; l < 4; l++) qos[l] = vecs[i].qos[4*l +: 4];
        run_txn(vecs[i].idx, vecs[i].aw, vecs[i].rw, vecs[i].d, vecs[i].rs, vecs[i].drop);
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 16'h0000, 2, 0, 0, 32'hDEADBEEF, 2'b00, 1'b1};
        vecs[1]  = '{4'b1001, 16'h7002, 3, 0, 0, 32'h11111111, 2'b00, 1'b1};
        vecs[2]  = '{4'b0000, 16'h7002, 0, 0, 0, 32'h22222222, 2'b00, 1'b1};
        vecs[3]  = '{4'b0011, 16'h0015, 0, 0, 0, 32'h33333333, 2'b01, 1'b1};
        vecs[4]  = '{4'b0000, 16'h0015, 1, 0, 0, 32'h44444444, 2'b00, 1'b1};
        vecs[5]  = '{4'b1000, 16'h3000, 3, 5, 4, 32'hCAFEF00D, 2'b00, 1'b1};
        vecs[6]  = '{4'b0001, 16'h0000, 0, 0, 0, 32'h0BADF00D, 2'b10, 1'b1};
        vecs[7]  = '{4'b0111, 16'h0000, 0, 0, 0, 32'h70707070, 2'b00, 1'b0};
        vecs[8]  = '{4'b0000, 16'h0000, 1, 0, 0, 32'h80808080, 2'b00, 1'b0};
        vecs[9]  = '{4'b0000, 16'h0000, 2, 0, 0, 32'h90909090, 2'b00, 1'b0};
        vecs[10] = '{4'b0000, 16'h0000, 0, 0, 0, 32'hA0A0A0A0, 2'b00, 1'b0};
        for (int i = 0; i < 4; i++) begin
            data[i] = addr_of(i);
            qos[i]  = '0;
        end
        slv.ar_ready = 1'b0;
        slv.r_valid  = 1'b0;
        slv.r_data   = '0;
        slv.r_resp   = '0;
        repeat (2) @(posedge clk);
        #1;
        val = 4'b1111;
        #1;
        chk("reset_ar_valid", 64'(slv.ar_valid), 0);
        chk("reset_reqst_rdy", 64'(rdy), 0);
        chk("reset_resp_val", 64'(resp_val), 0);
        chk("reset_r_ready", 64'(slv.r_ready), 0);
        chk("reset_rr_ptr", 64'(dut.rr_ptr_r), 0);
        val = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) apply(i);

        // Reset while a response is being offered: everything drops mid-cycle
        val = 4'b0010;
        @(posedge clk); #1;
        chk("rst_seq_ar_valid", 64'(slv.ar_valid), 1);
        slv.ar_ready = 1'b1;
        @(posedge clk); #1;
        slv.ar_ready = 1'b0;
        val = '0;
        chk("rst_seq_ptr_pre", 64'(dut.rr_ptr_r), 2);
        slv.r_valid = 1'b1;
        slv.r_data  = 32'h55AA55AA;
        resp_rdy    = 4'hF;
        #1;
        chk("rst_seq_resp_val", 64'(resp_val), 64'(4'b0010));
        chk("rst_seq_r_ready", 64'(slv.r_ready), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_resp_val", 64'(resp_val), 0);
        chk("rst_async_r_ready", 64'(slv.r_ready), 0);
        chk("rst_async_ar_valid", 64'(slv.ar_valid), 0);
        chk("rst_async_reqst_rdy", 64'(rdy), 0);
        slv.r_valid = 1'b0;
        resp_rdy    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ptr_cleared", 64'(dut.rr_ptr_r), 0);
        @(posedge clk); #1;
        chk("rst_idle_ar_valid", 64'(slv.ar_valid), 0);

        for (int i = 7; i < 11; i++) apply(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
